// File: rtl/video_sync_decoder.sv
// ---------------------------------------------------------------------------
// video_sync_decoder
//
// Recovers pixel coordinates from a raw hsync/vsync/rgb stream. It measures
// the line period and lines per frame, trains on a stable line length, and
// once locked emits registered x/y/pixel_rgb with a pixel_valid qualifier.
// Lock drops when a line length deviates by more than one clock or hsync
// disappears for H_TIMEOUT clocks.
//
// Optional feature macro: VIDEO_DECODER_STATS_EN
//   defined   -> frame_count / err_count statistics counters are built
//   undefined -> frame_count / err_count are tied to 0
//
// Ports
//   clk          in   pixel clock, rising edge
//   reset        in   asynchronous active-low reset, release synchronised
//   hsync        in   active-high horizontal sync
//   vsync        in   active-high vertical sync
//   rgb[2:0]     in   pixel colour {b,g,r}
//   x[8:0]       out  visible column (0 when pixel_valid is 0)
//   y[7:0]       out  visible line   (0 when pixel_valid is 0)
//   pixel_valid  out  x/y/pixel_rgb valid
//   pixel_rgb    out  rgb delayed one clock, aligned with x/y
//   frame_start  out  one-cycle pulse on a vsync leading edge while locked
//   locked       out  FSM is in LOCKED
//   line_len     out  last measured hsync period in clocks
//   frame_lines  out  last measured lines per frame
//   frame_count  out  locked frames received
//   err_count    out  lock-loss events, saturating
//
// state   | meaning
// --------+--------------------------------------------------------------
// SEARCH  | no timing reference, waiting for a vsync leading edge
// TRAIN   | counting consecutive equal-length lines
// LOCKED  | timing stable, pixels are decoded
// ---------------------------------------------------------------------------
module video_sync_decoder #(
    parameter int H_START    = 64,
    parameter int V_START    = 16,
    parameter int H_VISIBLE  = 256,
    parameter int V_VISIBLE  = 240,
    parameter int H_TIMEOUT  = 1023,
    parameter int LOCK_LINES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic        pixel_valid,
    output logic [2:0]  pixel_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic [15:0] frame_count,
    output logic [7:0]  err_count
);

    localparam logic [9:0] H_START_C  = 10'(H_START);
    localparam logic [9:0] H_END_C    = 10'(H_START + H_VISIBLE);
    localparam logic [9:0] V_START_C  = 10'(V_START);
    localparam logic [9:0] V_END_C    = 10'(V_START + V_VISIBLE);
    localparam logic [9:0] H_TMO_C    = 10'(H_TIMEOUT);
    localparam logic [9:0] LOCK_CNT_C = 10'(LOCK_LINES);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Reset asserts immediately and releases two clocks later, so the
    // sync registers only start sampling once the whole block is out of reset.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_int_n = rst_sync_q[1];

    state_t      state_q, state_d;
    logic        hs_q, vs_q;
    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic [9:0]  line_len_q, line_len_d;
    logic [9:0]  frame_lines_q, frame_lines_d;
    logic [9:0]  lock_len_q, lock_len_d;
    logic [9:0]  train_cnt_q, train_cnt_d;
    logic        pix_valid_q, pix_valid_d;
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [2:0]  pix_rgb_q, pix_rgb_d;
    logic        frame_start_q, frame_start_d;

    logic        hs_edge, vs_edge;
    logic [9:0]  hcount_p1;
    logic [9:0]  len_diff;
    logic        line_match;
    logic        lost;

    assign hs_edge   = hsync & ~hs_q;
    assign vs_edge   = vsync & ~vs_q;
    // Saturating +1 so a missing hsync measures as 1023, never wraps to 0.
    assign hcount_p1 = (hcount_q == 10'h3FF) ? 10'h3FF : hcount_q + 10'd1;
    assign line_match = (hcount_p1 == line_len_q);
    assign len_diff  = (hcount_p1 >= lock_len_q) ? (hcount_p1 - lock_len_q)
                                                 : (lock_len_q - hcount_p1);
    assign lost      = (state_q == ST_LOCKED) &&
                       ((hs_edge && (len_diff > 10'd1)) || (hcount_q == H_TMO_C));

    // Line / frame measurement runs in every state.
    always_comb begin
        hcount_d      = hs_edge ? 10'd0 : hcount_p1;
        line_len_d    = hs_edge ? hcount_p1 : line_len_q;
        vcount_d      = vcount_q;
        frame_lines_d = frame_lines_q;
        if (hs_edge) vcount_d = vcount_q + 10'd1;
        if (vs_edge) begin
            frame_lines_d = vcount_q;
            vcount_d      = 10'd0;
        end
    end

    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        lock_len_d  = lock_len_q;
        case (state_q)
            ST_SEARCH: begin
                if (vs_edge) begin
                    state_d     = ST_TRAIN;
                    train_cnt_d = 10'd0;
                end
            end
            ST_TRAIN: begin
                if (hs_edge) begin
                    if (!line_match)              train_cnt_d = 10'd0;
                    else if (train_cnt_q != 10'h3FF) train_cnt_d = train_cnt_q + 10'd1;
                end
                if (vs_edge && (train_cnt_q >= LOCK_CNT_C)) begin
                    state_d    = ST_LOCKED;
                    lock_len_d = line_len_d;
                end
            end
            ST_LOCKED: begin
                if (lost) state_d = ST_SEARCH;
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // Output stage: everything is decided from the current counters and
    // registered once, giving one clock from rgb sample to pixel_rgb.
    always_comb begin
        pix_valid_d   = (state_q == ST_LOCKED) &&
                        (hcount_q >= H_START_C) && (hcount_q < H_END_C) &&
                        (vcount_q >= V_START_C) && (vcount_q < V_END_C);
        x_d           = 9'd0;
        y_d           = 8'd0;
        pix_rgb_d     = 3'd0;
        if (pix_valid_d) begin
            x_d       = 9'(hcount_q - H_START_C);
            y_d       = 8'(vcount_q - V_START_C);
            pix_rgb_d = rgb;
        end
        // Covers the TRAIN->LOCKED edge as well as edges while locked.
        frame_start_d = vs_edge && (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q       <= ST_SEARCH;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            hcount_q      <= 10'd0;
            vcount_q      <= 10'd0;
            line_len_q    <= 10'd0;
            frame_lines_q <= 10'd0;
            lock_len_q    <= 10'd0;
            train_cnt_q   <= 10'd0;
            pix_valid_q   <= 1'b0;
            x_q           <= 9'd0;
            y_q           <= 8'd0;
            pix_rgb_q     <= 3'd0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hsync;
            vs_q          <= vsync;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            lock_len_q    <= lock_len_d;
            train_cnt_q   <= train_cnt_d;
            pix_valid_q   <= pix_valid_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_rgb_q     <= pix_rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pixel_valid = pix_valid_q;
    assign pixel_rgb   = pix_rgb_q;
    assign frame_start = frame_start_q;
    assign locked      = (state_q == ST_LOCKED);
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;

`ifdef VIDEO_DECODER_STATS_EN
    logic [15:0] frame_count_q;
    logic [7:0]  err_count_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            frame_count_q <= 16'd0;
            err_count_q   <= 8'd0;
        end else begin
            if (frame_start_d)                 frame_count_q <= frame_count_q + 16'd1;
            if (lost && (err_count_q != 8'hFF)) err_count_q  <= err_count_q + 8'd1;
        end
    end

    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
`else
    assign frame_count = 16'd0;
    assign err_count   = 8'd0;
`endif

endmodule

// File: tb/tb_video_sync_decoder.sv
module tb_video_sync_decoder;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [2:0]  rgb   = 3'd0;
    logic [8:0]  x;
    logic [7:0]  y;
    logic        pixel_valid;
    logic [2:0]  pixel_rgb;
    logic        frame_start;
    logic        locked;
    logic [9:0]  line_len;
    logic [9:0]  frame_lines;
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_errors = 0;

`ifdef VIDEO_DECODER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    video_sync_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .x           (x),
        .y           (y),
        .pixel_valid (pixel_valid),
        .pixel_rgb   (pixel_rgb),
        .frame_start (frame_start),
        .locked      (locked),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .frame_count (frame_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hsync = 1'b0;
            vsync = 1'b0;
        end
    endtask

    // One 262-line frame of 455-clock lines, 8-clock hsync, 3-line vsync
    // starting vs_off clocks into line 0. Outputs are sampled at the negedge
    // before the next inputs are applied, so they reflect the previous clock.
    task automatic run_frame(input int vs_off, input int stretch_line,
                             input bit pix_chk, input bit lock_chk,
                             input int abort_line, input int abort_c,
                             output int fs_seen);
        int len;
        fs_seen = 0;
        for (int l = 0; l < 262; l++) begin
            len = (l == stretch_line) ? 460 : 455;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                if (l == abort_line && c == abort_c) return;
                if (frame_start) fs_seen++;
                if (lock_chk && l == 0 && c == vs_off)     chk("lock_pre", locked, 0);
                if (lock_chk && l == 0 && c == vs_off + 1) chk("lock_rise", locked, 1);
                if (l == stretch_line + 1 && c == 0) chk("stretch_held", locked, 1);
                if (l == stretch_line + 1 && c == 1) begin
                    chk("stretch_drop", locked, 0);
                    chk("stretch_len", line_len, 460);
                end
                if (pix_chk) begin
                    if (l == 15 && c == 100) chk("pv_line15", pixel_valid, 0);
                    if (l == 16 && c == 65)  chk("pv_h63", pixel_valid, 0);
                    if (l == 16 && c == 66) begin
                        chk("pv_first", pixel_valid, 1);
                        chk("x_first", x, 0);
                        chk("y_first", y, 0);
                        chk("rgb_first", pixel_rgb, 3'b101);
                    end
                    if (l == 16 && c == 200) begin
                        chk("x_mid", x, 134);
                        chk("rgb_mid", pixel_rgb, 7);
                    end
                    if (l == 16 && c == 321) chk("x_last", x, 255);
                    if (l == 16 && c == 322) begin
                        chk("pv_h320", pixel_valid, 0);
                        chk("x_h320", x, 0);
                        chk("rgb_h320", pixel_rgb, 0);
                    end
                    if (l == 255 && c == 321) begin
                        chk("pv_corner", pixel_valid, 1);
                        chk("y_last", y, 239);
                    end
                    if (l == 256 && c == 100) begin
                        chk("pv_v256", pixel_valid, 0);
                        chk("y_v256", y, 0);
                    end
                end
                hsync = (c < 8);
                vsync = (l == 0 && c >= vs_off) || (l == 1) || (l == 2) ||
                        (l == 3 && c < vs_off);
                rgb   = 3'(c);
                if (l == 16 && c == 65) rgb = 3'b101;
            end
        end
    endtask

    initial begin
        int fs;
        #2 reset = 1'b0;
        idle(3);
        chk("rst_locked", locked, 0);
        chk("rst_pv", pixel_valid, 0);
        chk("rst_line_len", line_len, 0);
        chk("rst_frame_lines", frame_lines, 0);
        chk("rst_frame_count", frame_count, 0);
        reset = 1'b1;
        idle(5);

        run_frame(10, -10, 0, 0, -1, -1, fs);
        chk("f1_fs", fs, 0);
        chk("f1_locked", locked, 0);
        run_frame(10, -10, 0, 1, -1, -1, fs);
        chk("f2_fs", fs, 1);
        chk("f2_line_len", line_len, 455);
        chk("f2_frame_lines", frame_lines, 262);
        run_frame(10, -10, 1, 0, -1, -1, fs);
        chk("f3_fs", fs, 1);
        chk("f3_frame_lines", frame_lines, 262);

        // vsync edge on the same clock as the hsync edge
        run_frame(0, -10, 0, 0, -1, -1, fs);
        chk("f4_fs", fs, 1);
        chk("coinc_frame_lines", frame_lines, 261);
        run_frame(0, -10, 1, 0, -1, -1, fs);
        chk("f5_fs", fs, 1);
        chk("coinc_frame_lines2", frame_lines, 261);
        chk("f5_locked", locked, 1);

        // line 100 stretched to 460 clocks
        run_frame(10, 100, 0, 0, -1, -1, fs);
        chk("f6_fs", fs, 1);
        chk("f6_frame_lines", frame_lines, 262);
        chk("f6_err_count", err_count, STATS ? 32'd1 : 32'd0);
        chk("f6_frame_count", frame_count, STATS ? 32'd5 : 32'd0);
        run_frame(10, -10, 0, 0, -1, -1, fs);
        chk("f7_fs", fs, 0);
        chk("f7_locked", locked, 0);
        run_frame(10, -10, 0, 1, -1, -1, fs);
        chk("f8_fs", fs, 1);
        chk("f8_frame_count", frame_count, STATS ? 32'd6 : 32'd0);

        // one hsync pulse then hsync held low
        for (int i = 0; i <= 1025; i++) begin
            @(negedge clk);
            if (i == 1024) chk("tmo_held", locked, 1);
            if (i == 1025) begin
                chk("tmo_drop", locked, 0);
                chk("tmo_pv", pixel_valid, 0);
                chk("tmo_x", x, 0);
                chk("tmo_y", y, 0);
            end
            hsync = (i < 8);
            vsync = 1'b0;
            rgb   = 3'b111;
        end
        chk("tmo_err_count", err_count, STATS ? 32'd2 : 32'd0);

        run_frame(10, -10, 0, 0, -1, -1, fs);
        run_frame(10, -10, 0, 1, -1, -1, fs);
        chk("f10_fs", fs, 1);

        // reset mid-line while locked and inside the visible window
        run_frame(10, -10, 0, 0, 20, 100, fs);
        chk("pre_rst_locked", locked, 1);
        chk("pre_rst_pv", pixel_valid, 1);
        chk("pre_rst_x", x, 34);
        chk("pre_rst_y", y, 4);
        reset = 1'b0;
        hsync = 1'b0;
        vsync = 1'b0;
        #1;
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_pv", pixel_valid, 0);
        chk("mid_rst_x", x, 0);
        chk("mid_rst_y", y, 0);
        chk("mid_rst_line_len", line_len, 0);
        chk("mid_rst_frame_lines", frame_lines, 0);
        chk("mid_rst_frame_count", frame_count, 0);
        chk("mid_rst_err_count", err_count, 0);
        idle(2);
        reset = 1'b1;
        idle(5);
        run_frame(10, -10, 0, 0, -1, -1, fs);
        chk("r1_fs", fs, 0);
        chk("r1_locked", locked, 0);
        run_frame(10, -10, 0, 1, -1, -1, fs);
        chk("r2_fs", fs, 1);
        chk("r2_line_len", line_len, 455);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
